// File: rtl/pmod_write_cmd_if.sv
// Byte-stream / budIf write-command bundle between the Pmod receiver, the
// command decoder and budIf.
interface pmod_write_cmd_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        write_req;
    logic        read_req;
    logic [9:0]  len;
    logic [31:0] address;
    logic [63:0] wdata;
    logic        pkt_done;
    logic        err;

    modport master (
        input  rx_data, rx_valid, busy,
        output rx_ready, write_req, read_req, len, address, wdata, pkt_done, err
    );

    modport slave (
        output rx_data, rx_valid, busy,
        input  rx_ready, write_req, read_req, len, address, wdata, pkt_done, err
    );
endinterface

// File: rtl/pmod_write_cmd.sv
// Parses host write packets (cmd, len, address, payload), stages the payload
// into 64-bit words and hands them to budIf under its busy-gated protocol.
module pmod_write_cmd #(
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic             M_AXI_ACLK,
    input  logic             M_AXI_ARESET,
    pmod_write_cmd_if.master bus
);
    localparam int unsigned AW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [7:0]  CMD_WRITE = 8'h57;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_ADDR, S_DATA, S_ISSUE, S_STREAM
    } state_t;

    state_t        state, state_n;
    logic [1:0]    hdr_cnt;
    logic [7:0]    len_lo;
    logic [10:0]   byte_cnt, pbytes;
    logic [7:0]    beats, remain, rd_idx;
    logic          sub;
    logic [9:0]    len_q;
    logic [31:0]   addr_q;
    logic [63:0]   wdata_q;
    logic          write_req_q, pkt_done_q, err_q;
    logic [63:0]   mem [MAX_BEATS];

    logic          hs, err_n, done_n;
    logic [15:0]   len_full;
    logic [6:0]    len_n;
    logic [2:0]    len_code;
    logic [7:0]    beats_w;
    logic [10:0]   pbytes_w;
    logic          sub_w, len_ok;
    logic [2:0]    lane;
    logic [AW-1:0] word;

    assign bus.rx_ready  = (state == S_IDLE) || (state == S_LEN) ||
                           (state == S_ADDR) || (state == S_DATA);
    assign bus.write_req = write_req_q;
    assign bus.read_req  = 1'b0;
    assign bus.len       = len_q;
    assign bus.address   = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.pkt_done  = pkt_done_q;
    assign bus.err       = err_q;

    assign hs       = bus.rx_valid & bus.rx_ready;
    assign len_full = {bus.rx_data, len_lo};
    assign len_n    = len_full[9:3];
    assign len_code = len_full[2:0];
    // Sub-word payloads are placed at the address offset; full words start at lane 0.
    assign lane     = sub ? (addr_q[2:0] + byte_cnt[2:0]) : byte_cnt[2:0];
    assign word     = byte_cnt[AW+2:3];

    always_comb begin
        beats_w  = 8'd1;
        pbytes_w = '0;
        sub_w    = 1'b0;
        len_ok   = 1'b0;
        if (len_n != '0) begin
            beats_w  = {1'b0, len_n} + 8'd1;
            pbytes_w = {beats_w, 3'b000};
            len_ok   = (len_code == 3'd0) && (32'(beats_w) <= MAX_BEATS);
        end else begin
            case (len_code)
                3'd1:       begin pbytes_w = 11'd1; sub_w = 1'b1; len_ok = 1'b1; end
                3'd2:       begin pbytes_w = 11'd2; sub_w = 1'b1; len_ok = 1'b1; end
                3'd4:       begin pbytes_w = 11'd4; sub_w = 1'b1; len_ok = 1'b1; end
                3'd6, 3'd7: begin pbytes_w = 11'd8; len_ok = 1'b1; end
                default:    len_ok = 1'b0;
            endcase
        end
        if (len_full[15:10] != '0)
            len_ok = 1'b0;
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        done_n  = 1'b0;
        case (state)
            S_IDLE:
                if (hs) begin
                    if (bus.rx_data == CMD_WRITE) state_n = S_LEN;
                    else                          err_n   = 1'b1;
                end
            S_LEN:
                if (hs && hdr_cnt == 2'd1) begin
                    if (len_ok) begin
                        state_n = S_ADDR;
                    end else begin
                        state_n = S_IDLE;
                        err_n   = 1'b1;
                    end
                end
            S_ADDR:
                if (hs && hdr_cnt == 2'd3) state_n = S_DATA;
            S_DATA:
                if (hs && byte_cnt == pbytes - 11'd1) state_n = S_ISSUE;
            S_ISSUE:
                if (!bus.busy) state_n = S_STREAM;
            S_STREAM:
                if (!bus.busy && remain == 8'd1) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            default:
                state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (state == S_DATA && hs && word != '0)
            mem[word][{lane, 3'b000} +: 8] <= bus.rx_data;
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            hdr_cnt     <= '0;
            len_lo      <= '0;
            byte_cnt    <= '0;
            pbytes      <= '0;
            beats       <= '0;
            remain      <= '0;
            rd_idx      <= '0;
            sub         <= 1'b0;
            len_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_req_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q       <= err_n;
            pkt_done_q  <= done_n;
            write_req_q <= (state_n == S_ISSUE);
            case (state)
                S_IDLE:
                    hdr_cnt <= '0;
                S_LEN:
                    if (hs) begin
                        if (hdr_cnt == 2'd0) begin
                            len_lo  <= bus.rx_data;
                            hdr_cnt <= 2'd1;
                        end else begin
                            hdr_cnt <= '0;
                            if (len_ok) begin
                                len_q  <= len_full[9:0];
                                beats  <= beats_w;
                                pbytes <= pbytes_w;
                                sub    <= sub_w;
                            end
                        end
                    end
                S_ADDR:
                    if (hs) begin
                        addr_q[{hdr_cnt, 3'b000} +: 8] <= bus.rx_data;
                        hdr_cnt  <= hdr_cnt + 2'd1;
                        byte_cnt <= '0;
                        if (hdr_cnt == 2'd3)
                            wdata_q <= '0;
                    end
                // Word 0 is assembled straight into wdata so it is ready when write_req rises.
                S_DATA:
                    if (hs) begin
                        byte_cnt <= byte_cnt + 11'd1;
                        if (word == '0)
                            wdata_q[{lane, 3'b000} +: 8] <= bus.rx_data;
                    end
                S_ISSUE:
                    if (!bus.busy) begin
                        remain <= beats;
                        rd_idx <= 8'd2;
                        if (beats > 8'd1)
                            wdata_q <= mem[AW'(1)];
                    end
                S_STREAM:
                    if (!bus.busy) begin
                        remain <= remain - 8'd1;
                        if (rd_idx < beats) begin
                            wdata_q <= mem[rd_idx[AW-1:0]];
                            rd_idx  <= rd_idx + 8'd1;
                        end
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pmod_write_cmd.sv
// Self-checking bench for pmod_write_cmd: directed packets from the test plan
// plus randomized packets checked against a payload-placement model.
module tb_pmod_write_cmd;
    localparam int MB = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pmod_write_cmd_if bus();

    pmod_write_cmd #(.MAX_BEATS(MB)) dut (
        .M_AXI_ACLK  (clk),
        .M_AXI_ARESET(rst),
        .bus         (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0]  payload [0:1023];
    logic [63:0] exp_w   [0:127];

    // Payload byte count for a len code, or -1 when the header is rejected.
    function automatic int model_pbytes(input int lenv);
        int code, n;
        if ((lenv >> 10) != 0) return -1;
        code = lenv % 8;
        n    = (lenv / 8) % 128;
        if (n > 0) begin
            if (code != 0 || n + 1 > MB) return -1;
            return 8 * (n + 1);
        end
        case (code)
            1: return 1;
            2: return 2;
            4: return 4;
            6, 7: return 8;
            default: return -1;
        endcase
    endfunction

    task automatic build_words(input int p, input logic [31:0] addr);
        int lane, wi;
        for (int w = 0; w < 128; w++) exp_w[w] = '0;
        for (int k = 0; k < p; k++) begin
            if (p < 8) begin
                lane = (int'(addr[2:0]) + k) % 8;
                wi   = 0;
            end else begin
                lane = k % 8;
                wi   = k / 8;
            end
            exp_w[wi] = exp_w[wi] | (64'(payload[k]) << (8 * lane));
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_byte(input logic [7:0] b, input bit toggle, output bit ok);
        ok = 1'b0;
        bus.rx_data = b;
        for (int t = 0; t < 64; t++) begin
            bus.rx_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (bus.rx_valid && bus.rx_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic run_packet(input int lenv, input logic [31:0] addr, input int busy_mode,
                              input bit toggle, input string tag);
        int p, b, cons, hold, idx, last_cons, cyc_done;
        bit ok, all_ok, seen_wr, done, first, bad_wr, bad_side, phase;
        p = model_pbytes(lenv);
        all_ok = 1'b1;
        send_byte(8'h57, toggle, ok);            all_ok &= ok;
        send_byte(8'(lenv), toggle, ok);         all_ok &= ok;
        send_byte(8'(lenv >> 8), toggle, ok);    all_ok &= ok;
        if (p < 0) begin
            @(negedge clk);
            n_cmp++;
            if (bus.err !== 1'b1) begin
                n_mis++; $display("FAIL %s reject err: got %b want 1", tag, bus.err);
            end
            n_cmp++;
            if (bus.rx_ready !== 1'b1) begin
                n_mis++; $display("FAIL %s reject rx_ready: got %b want 1", tag, bus.rx_ready);
            end
            seen_wr = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (bus.write_req !== 1'b0 || bus.err !== 1'b0) seen_wr = 1'b1;
            end
            n_cmp++;
            if (seen_wr || !all_ok) begin
                n_mis++; $display("FAIL %s reject quiet: got write_req/err activity=%b handshake_ok=%b want 0/1",
                                  tag, seen_wr, all_ok);
            end
            @(posedge clk); #1;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(addr[8*i +: 8], toggle, ok); all_ok &= ok;
        end
        for (int k = 0; k < p; k++) begin
            send_byte(payload[k], toggle, ok); all_ok &= ok;
        end
        n_cmp++;
        if (!all_ok) begin
            n_mis++; $display("FAIL %s handshake: got timeout want all bytes accepted", tag);
        end
        build_words(p, addr);
        b = (p < 8) ? 1 : p / 8;
        phase = 1'b0; first = 1'b1; cons = 0; hold = 0; done = 1'b0;
        bad_wr = 1'b0; bad_side = 1'b0; last_cons = -10; cyc_done = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            case (busy_mode)
                0:       bus.busy = 1'b0;
                1:       bus.busy = 1'($urandom_range(0, 1));
                default: bus.busy = (phase && hold < 2);
            endcase
            @(negedge clk);
            if (bus.pkt_done === 1'b1) begin
                done = 1'b1; cyc_done = cyc;
                break;
            end
            if (bus.rx_ready !== 1'b0 || bus.err !== 1'b0 || bus.read_req !== 1'b0) bad_side = 1'b1;
            if (!phase) begin
                if (first) begin
                    first = 1'b0;
                    n_cmp++;
                    if (bus.len !== 10'(lenv) || bus.address !== addr) begin
                        n_mis++; $display("FAIL %s header: got len %h addr %h want len %h addr %h",
                                          tag, bus.len, bus.address, 10'(lenv), addr);
                    end
                end
                if (bus.write_req !== 1'b1) bad_wr = 1'b1;
                if (!bus.busy) begin
                    n_cmp++;
                    if (bus.wdata !== exp_w[0]) begin
                        n_mis++; $display("FAIL %s accept wdata: got %h want %h", tag, bus.wdata, exp_w[0]);
                    end
                    phase = 1'b1;
                end
            end else begin
                if (bus.write_req !== 1'b0) bad_wr = 1'b1;
                if (!bus.busy) begin
                    idx = (cons + 1 < b) ? cons + 1 : b - 1;
                    n_cmp++;
                    if (bus.wdata !== exp_w[idx]) begin
                        n_mis++; $display("FAIL %s stream wdata[%0d]: got %h want %h",
                                          tag, cons, bus.wdata, exp_w[idx]);
                    end
                    cons++;
                    last_cons = cyc;
                end
                hold++;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!done || cons != b || cyc_done != last_cons + 1) begin
            n_mis++; $display("FAIL %s drain: got done=%b consumptions %0d at %0d/%0d want done=1 %0d next cycle",
                              tag, done, cons, last_cons, cyc_done, b);
        end
        n_cmp++;
        if (bad_wr || bad_side) begin
            n_mis++; $display("FAIL %s control: got write_req_bad=%b side_bad=%b want 0/0", tag, bad_wr, bad_side);
        end
        bus.busy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (bus.rx_ready !== 1'b1 || bus.write_req !== 1'b0 || bus.read_req !== 1'b0 ||
            bus.pkt_done !== 1'b0 || bus.err !== 1'b0) begin
            n_mis++; $display("FAIL reset ctrl: got rdy%b wr%b rd%b done%b err%b want 1 0 0 0 0",
                              bus.rx_ready, bus.write_req, bus.read_req, bus.pkt_done, bus.err);
        end
        n_cmp++;
        if (bus.len !== '0 || bus.address !== '0 || bus.wdata !== '0) begin
            n_mis++; $display("FAIL reset data: got len %h addr %h wdata %h want 0",
                              bus.len, bus.address, bus.wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_byte();
        payload[0] = 8'hA5;
        run_packet(1, 32'h4000_0003, 0, 1'b0, "single");
    endtask

    task automatic test_halfword();
        payload[0] = 8'h11;
        payload[1] = 8'h22;
        run_packet(2, 32'h1000_0006, 0, 1'b0, "halfword");
    endtask

    task automatic test_burst();
        for (int k = 0; k < 24; k++) payload[k] = 8'(k);
        run_packet(16, 32'h2000_0000, 2, 1'b0, "burst");
    endtask

    task automatic test_bad_cmd();
        bit ok;
        send_byte(8'h52, 1'b0, ok);
        @(negedge clk);
        n_cmp++;
        if (bus.err !== 1'b1 || !ok) begin
            n_mis++; $display("FAIL bad_cmd err: got %b want 1", bus.err);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.err !== 1'b0 || bus.rx_ready !== 1'b1) begin
            n_mis++; $display("FAIL bad_cmd pulse: got err %b rdy %b want 0 1", bus.err, bus.rx_ready);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) payload[k] = 8'($urandom);
        run_packet(4, 32'h0000_1234, 0, 1'b0, "after_bad_cmd");
    endtask

    task automatic test_bad_len();
        run_packet(16'h0088, 32'h0, 0, 1'b0, "len_0088");
        run_packet(0, 32'h0, 0, 1'b0, "len_0");
        run_packet(3, 32'h0, 0, 1'b0, "len_3");
        run_packet(5, 32'h0, 0, 1'b0, "len_5");
        run_packet(9, 32'h0, 0, 1'b0, "len_burst_code");
        run_packet(16'h0401, 32'h0, 0, 1'b0, "len_hibits");
        payload[0] = 8'h5A;
        run_packet(1, 32'h0000_0007, 0, 1'b0, "after_bad_len");
    endtask

    task automatic test_reset_mid_burst();
        bit ok, all_ok, bad;
        all_ok = 1'b1;
        for (int k = 0; k < 32; k++) payload[k] = 8'($urandom);
        send_byte(8'h57, 1'b0, ok); all_ok &= ok;
        send_byte(8'h18, 1'b0, ok); all_ok &= ok;
        send_byte(8'h00, 1'b0, ok); all_ok &= ok;
        for (int i = 0; i < 4; i++) begin send_byte(8'h80, 1'b0, ok); all_ok &= ok; end
        for (int k = 0; k < 32; k++) begin send_byte(payload[k], 1'b0, ok); all_ok &= ok; end
        bus.busy = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (!all_ok || bus.rx_ready !== 1'b1 || bus.write_req !== 1'b0 || bus.pkt_done !== 1'b0 ||
            bus.err !== 1'b0 || bus.len !== '0 || bus.address !== '0 || bus.wdata !== '0) begin
            n_mis++; $display("FAIL mid_reset outputs: got rdy%b wr%b done%b err%b len %h addr %h wdata %h want reset values",
                              bus.rx_ready, bus.write_req, bus.pkt_done, bus.err, bus.len, bus.address, bus.wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.write_req !== 1'b0 || bus.pkt_done !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_mis++; $display("FAIL mid_reset quiet: got write_req/pkt_done activity want none");
        end
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) payload[k] = 8'($urandom);
        run_packet(8, 32'h0000_0100, 1, 1'b0, "after_reset");
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 24; k++) payload[k] = 8'(k);
        run_packet(16, 32'h2000_0000, 0, 1'b1, "backpressure_burst");
        for (int k = 0; k < 8; k++) payload[k] = 8'($urandom);
        run_packet(7, 32'h3000_0005, 1, 1'b1, "backpressure_word");
    endtask

    task automatic test_random();
        int lenv, sel, p;
        logic [31:0] addr;
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: lenv = 1;
                1: lenv = 2;
                2: lenv = 4;
                3: lenv = 6 + int'($urandom_range(0, 1));
                4, 5, 6: lenv = 8 * int'($urandom_range(1, 16));
                7: lenv = int'($urandom_range(0, 7));
                8: lenv = 8 * int'($urandom_range(1, 127)) + int'($urandom_range(0, 7));
                default: lenv = int'($urandom_range(0, 16'hFFFF));
            endcase
            addr = $urandom;
            p = model_pbytes(lenv);
            for (int k = 0; k < 1024; k++) payload[k] = 8'($urandom);
            if (p > 8 * MB) p = 0;
            run_packet(lenv, addr, 1, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.busy     = 1'b0;
        test_reset();
        test_single_byte();
        test_halfword();
        test_burst();
        test_bad_cmd();
        test_bad_len();
        test_reset_mid_burst();
        test_backpressure();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/pmod_write_cmd.md
# pmod_write_cmd

Byte-stream command decoder between the Pmod link receiver and `budIf`. It parses write packets from the host, stages the payload into 64-bit words, and drives `budIf`'s `write_req`/`len`/`address`/`wdata` using that block's `busy`-gated consumption protocol. Reads are not supported, and `read_req` is held low.

## Interface
- `MAX_BEATS`, default 16: burst buffer depth in 64-bit words. Must be a power of 2, 2..128.
- `M_AXI_ACLK` in 1: the single clock.
- `M_AXI_ARESET` in 1: asynchronous, active-high reset.
- `rx_data` in 8: payload byte from the link receiver.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: a byte is accepted when `rx_valid & rx_ready`.
- `busy` in 1: from `budIf`.
- `write_req` out 1: write request to `budIf`.
- `read_req` out 1: constant 0.
- `len` out 10: `budIf` length code.
- `address` out 32: byte address.
- `wdata` out 64: current data word.
- `pkt_done` out 1: one-cycle pulse when a packet fully drains.
- `err` out 1: one-cycle pulse when a packet is rejected.

## Operation
- Packet format: `cmd` (0x57), `len` (2 bytes, little-endian, bits 15:10 must be 0), `address` (4 bytes, little-endian), then the payload.
- Payload byte count P is set by `len[2:0]`:
  - 1 → 1 byte.
  - 2 → 2 bytes.
  - 4 → 4 bytes.
  - 6 or 7 → 8 bytes.
  - 0 with `len[9:3]=n>0` → 8(n+1) bytes.
- Beat count B is 1 for every non-burst code, and n+1 for a burst.
- Rejected values, each producing `err` and a return to IDLE before any payload is consumed:
  - `len` = 0, 3, or 5.
  - `len[9:3]≠0` with `len[2:0]≠0`.
  - n+1 > `MAX_BEATS`.
  - `len[15:10]≠0`.
- A `cmd` byte other than 0x57 is dropped with an `err` pulse, and the block stays in IDLE.
- Sub-word payloads (P<8): byte i goes to lane `(address[2:0]+i) mod 8`. All other lanes are 0.
- Full words: payload byte k goes to word k/8, lane k mod 8.
- States and transitions:
  - IDLE → LEN (2 bytes) → ADDR (4 bytes) → DATA (P bytes) → ISSUE → STREAM → IDLE.
  - `rx_ready` is 1 in IDLE, LEN, ADDR and DATA, and 0 in ISSUE and STREAM.
- ISSUE:
  - `write_req`=1 with `wdata` = word 0; `len` and `address` hold the latched header.
  - A cycle with `busy=0` is the accept cycle. `write_req` drops next cycle, `wdata` advances to word 1, and the state moves to STREAM with the remaining count set to B.
- STREAM:
  - Each `busy=0` cycle is a consumption: the remaining count decrements and `wdata` advances to the next word.
  - Past word B-1, `wdata` holds its last value.
  - The consumption that takes the remaining count to 0 is the drain of the WLAST beat. It pulses `pkt_done` and returns the state to IDLE.
  - `write_req` stays low throughout STREAM. Asserting it mid-burst would restart `budIf`.
- `len` and `address` stay stable from ISSUE until the next header is latched.

## Timing
- Reset values (asynchronous, active-high):
  - State = IDLE; `rx_ready`=1.
  - `write_req`, `read_req`, `pkt_done`, `err` = 0.
  - `len`=0, `address`=0, `wdata`=0.
  - Buffer contents are don't-care.
- Reset asserted mid-packet or mid-burst aborts immediately. No `pkt_done` is produced, and no `write_req` is produced until a fresh packet arrives.
- `write_req` is registered and rises in the cycle after the final payload byte handshake.
- Minimum write_req-high to IDLE: B+1 cycles when `busy` is held 0.
- When `busy=1`, `write_req` and `wdata` hold.
- Consumption depends only on `busy=0` in STREAM, never on `rx_valid`.
- `err` and `pkt_done` never assert in the same cycle.
- The first byte of the next packet can be accepted in the cycle after the return to IDLE.

## Test plan
- **Single byte:** 57 01 00 03 00 00 40 A5 → one `write_req` with `len`=1, `address`=0x40000003, `wdata`=0x00000000A5000000. `pkt_done` pulses 2 cycles after accept.
- **Halfword at offset 6:** `len`=2, addr 0x10000006, payload 11 22 → `wdata`=0x2211000000000000.
- **Burst:** `len`=16 (B=3), 24 bytes 00..17, with `busy` high for 2 cycles after accept:
  - `wdata` sequence 0x0706050403020100, 0x0F0E0D0C0B0A0908, 0x1716151413121110.
  - Exactly 3 `busy=0` consumptions in STREAM.
  - `write_req` high for only one accepted cycle.
- **Bad inputs:**
  - `cmd` 0x52 → `err` pulse, byte dropped, next valid packet processed normally.
  - `len`=0x0088 with `MAX_BEATS`=16 → `err`, no `write_req`.
- **Reset mid-burst:** assert `M_AXI_ARESET` in STREAM → all outputs return to reset values the same cycle, no `pkt_done`, and a subsequent packet completes correctly.
- **Backpressure:** `rx_valid` toggling 50% during DATA → same `wdata` words as the gap-free case. `rx_ready`=0 throughout ISSUE and STREAM.
